sd_spi_byte: RTL

- Full-duplex SPI byte transceiver that sits directly between the SD-card controller FSM and the card pins.
- The controller hands it one byte plus a speed select. The block shifts the byte out on MOSI while capturing MISO, then returns the received byte with a one-cycle done pulse.
- Owns the pin registers (CS, SCLK, MOSI). The controller never drives pins directly; slow init clocking and fast data clocking both go through this block.

---
 rtl/sd_spi_pkg.sv | 24 ++
 rtl/sd_spi_byte_if.sv | 21 ++
 rtl/sd_crc7.sv | 27 ++
 rtl/sd_spi_byte.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI byte transceiver.
// The optional CRC7 generator is built when SD_SPI_CRC7_EN is defined.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_t;

  // MOSI idles high, which is what the card sees as an 0xFF filler byte.
  localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

  // x^7 + x^3 + 1
  localparam logic [6:0] SD_CRC7_POLY = 7'h09;

  // One bit-serial CRC7 step, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_byte_if.sv
// Controller-side handshake of the SPI byte transceiver.
// master = SD-card controller FSM, slave = sd_spi_byte.
interface sd_spi_byte_if;
  logic       start;
  logic       speed;
  logic [7:0] tx_data;
  logic       cs_level;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;

  modport master (
    output start, speed, tx_data, cs_level,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, speed, tx_data, cs_level,
    output rx_data, busy, done
  );
endinterface

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 register for SD command framing.
// Only instantiated when SD_SPI_CRC7_EN is defined.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  // Clear takes priority over an update landing in the same cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_crc <= 7'h00;
    end else if (i_en) begin
      r_crc <= crc7_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_spi_byte.sv
// Full-duplex SPI mode-0 byte transceiver between the SD controller and the card pins.
// Owns the CS/SCLK/MOSI pin registers. Define SD_SPI_CRC7_EN to add a running
// CRC7 over transmitted bits (i_crc_clear / o_crc7).
//
// state | meaning
// IDLE  | SCLK low, MOSI high, waiting for start
// LOW   | SCLK low half-period, MOSI holds current bit; MISO sampled on exit
// HIGH  | SCLK high half-period; on exit shift next bit or finish the byte
module sd_spi_byte
  import sd_spi_pkg::*;
#(
  parameter int SLOW_DIV = 125,
  parameter int FAST_DIV = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  sd_spi_byte_if.slave bus,
  output logic         o_spi_cs,
  output logic         o_spi_sclk,
  output logic         o_spi_mosi,
  input  logic         i_spi_miso
`ifdef SD_SPI_CRC7_EN
  ,
  input  logic         i_crc_clear,
  output logic [6:0]   o_crc7
`endif
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = $clog2(MAX_DIV) + 1;
  localparam logic [CW-1:0] SLOW_V = CW'(SLOW_DIV);
  localparam logic [CW-1:0] FAST_V = CW'(FAST_DIV);

  spi_state_t    r_state;
  spi_state_t    w_next;
  logic [CW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [7:0]    r_rx_data;
  logic          r_busy;
  logic          r_done;
  logic          r_cs;
  logic          r_sclk;
  logic          r_mosi;

  logic          w_tc;
  logic          w_load;
  logic          w_rise;
  logic          w_fall;
  logic          w_last;

  assign w_tc = (r_cnt == (r_div - CW'(1)));

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: each half-period ends on the divider terminal count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = LOW;
      LOW:     if (w_tc) w_next = HIGH;
      HIGH:    if (w_tc) w_next = (r_bit == 3'd7) ? IDLE : LOW;
      default: w_next = IDLE;
    endcase
  end

  // Decoded strobes that drive the datapath registers.
  always_comb begin
    w_load = 1'b0;
    w_rise = 1'b0;
    w_fall = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE: w_load = bus.start;
      LOW:  w_rise = w_tc;
      HIGH: begin
        w_fall = w_tc;
        w_last = w_tc && (r_bit == 3'd7);
      end
      default: ;
    endcase
  end

  // Pin, shift and divider registers; start/speed/tx_data only matter at load.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_rx_data <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b1;
    end else begin
      r_cs   <= bus.cs_level;
      r_done <= 1'b0;
      if (w_load) begin
        r_tx   <= bus.tx_data;
        r_div  <= bus.speed ? FAST_V : SLOW_V;
        r_cnt  <= '0;
        r_bit  <= 3'd0;
        r_busy <= 1'b1;
        r_mosi <= bus.tx_data[7];
      end else if (r_state != IDLE) begin
        r_cnt <= w_tc ? '0 : (r_cnt + CW'(1));
        if (w_rise) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], i_spi_miso};
        end
        if (w_fall) begin
          r_sclk <= 1'b0;
          if (w_last) begin
            r_mosi    <= SD_IDLE_BYTE[7];
            r_rx_data <= r_rx;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_bit  <= r_bit + 3'd1;
            r_mosi <= r_tx[6];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign o_spi_cs    = r_cs;
  assign o_spi_sclk  = r_sclk;
  assign o_spi_mosi  = r_mosi;

`ifdef SD_SPI_CRC7_EN
  // The bit on MOSI at the SCLK rising edge is the bit the card latches.
  sd_crc7 u_crc7 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_crc_clear),
    .i_en    (w_rise),
    .i_bit   (r_mosi),
    .o_crc   (o_crc7)
  );
`endif

endmodule
